// File: rtl/sum_accumulator.sv
// Clocked frame accumulator fed by a four-phase bundled-data channel; emits COUNT-sum totals on valid/ready.
// Optional SUM_ACC_SAT_EN: saturate the accumulator on carry out instead of wrapping.
module sum_accumulator #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sum_req,
  input  logic [WIDTH-1:0]     sum_data,
  output logic                 sum_ack,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_data,
  output logic                 acc_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT);

  typedef enum logic [1:0] {ARM, IDLE, ACK, EMIT} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic                   ack_q;
  logic                   valid_q;
  logic                   req_s;
  logic [ACC_WIDTH:0]     sum_d;

  // Bit ACC_WIDTH of the result is the carry out of the unsaturated add.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0]     b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, b};
`ifdef SUM_ACC_SAT_EN
    if (s[ACC_WIDTH]) s = {1'b1, {ACC_WIDTH{1'b1}}};
`endif
    return s;
  endfunction

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign sum_d     = acc_add(acc_q, sum_data);
  assign sum_ack   = ack_q;
  assign acc_valid = valid_q;
  assign acc_data  = acc_q;
  assign acc_ovf   = ovf_q;

  // fill_q marks when req_s reflects a post-reset sample, so a request held
  // through reset cannot slip past ARM while the synchroniser is still zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARM;
      sync_q  <= '0;
      fill_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sum_req};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      case (state_q)
        ARM: begin
          if (fill_q[SYNC_STAGES-1] && !req_s) state_q <= IDLE;
        end
        IDLE: begin
          if (req_s) begin
            acc_q   <= sum_d[ACC_WIDTH-1:0];
            ovf_q   <= ovf_q | sum_d[ACC_WIDTH];
            cnt_q   <= cnt_q + CNT_W'(1);
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_q <= 1'b0;
            if (cnt_q == CNT_MAX) begin
              valid_q <= 1'b1;
              state_q <= EMIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        EMIT: begin
          if (valid_q && acc_ready) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: a 16-bit/COUNT=4 instance and an 8-bit/COUNT=2 instance against a frame-sum model.
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req [2];
  logic        ack [2];
  logic        vld [2];
  logic        rdy [2];
  logic        ovf [2];
  logic [7:0]  dat [2];
  logic [15:0] accd_a;
  logic [7:0]  accd_b;

  int n_chk = 0;
  int n_pass = 0;
  int xfer_a = 0;
  int xfer_b = 0;
  int exp_xa = 0;
  int exp_xb = 0;
  int stim [4];

  sum_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .sum_req(req[0]), .sum_data(dat[0]), .sum_ack(ack[0]),
    .acc_valid(vld[0]), .acc_ready(rdy[0]), .acc_data(accd_a), .acc_ovf(ovf[0]));

  sum_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .COUNT(2), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(reset), .sum_req(req[1]), .sum_data(dat[1]), .sum_ack(ack[1]),
    .acc_valid(vld[1]), .acc_ready(rdy[1]), .acc_data(accd_b), .acc_ovf(ovf[1]));

  always @(posedge clk) if (vld[0] && rdy[0]) xfer_a <= xfer_a + 1;
  always @(posedge clk) if (vld[1] && rdy[1]) xfer_b <= xfer_b + 1;

  function automatic logic [15:0] accd(input int sel);
    return (sel != 0) ? {8'h00, accd_b} : accd_a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame total from plain integer arithmetic over the sample list.
  function automatic void frame_exp(input int n, input int aw, output int d, output int o);
    int total = 0;
    int maxv  = (1 << aw) - 1;
    for (int i = 0; i < n; i++) total += stim[i];
    o = (total > maxv) ? 1 : 0;
`ifdef SUM_ACC_SAT_EN
    d = (total > maxv) ? maxv : total;
`else
    d = total & maxv;
`endif
  endfunction

  task automatic req_up(input int sel, input logic [7:0] v);
    @(negedge clk);
    dat[sel] = v;
    req[sel] = 1'b1;
    for (int i = 0; i < 40 && !ack[sel]; i++) tick();
    chk("ack_rise", ack[sel], 1);
  endtask

  task automatic req_down(input int sel);
    @(negedge clk);
    req[sel] = 1'b0;
    for (int i = 0; i < 40 && ack[sel]; i++) tick();
    chk("ack_fall", ack[sel], 0);
  endtask

  task automatic run_frame(input int sel, input int n, input int first);
    int d, o;
    for (int i = first; i < n; i++) begin
      req_up(sel, stim[i][7:0]);
      req_down(sel);
    end
    frame_exp(n, (sel != 0) ? 8 : 16, d, o);
    chk("frame_valid", vld[sel], 1);
    chk("frame_data", accd(sel), d);
    chk("frame_ovf", ovf[sel], o);
    if (sel != 0) exp_xb++;
    else exp_xa++;
  endtask

  initial begin
    logic        seen;
    logic [15:0] held;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0;
      dat[s] = 8'h00;
      rdy[s] = 1'b1;
    end
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", ack[s], 0);
      chk("rst_valid", vld[s], 0);
      chk("rst_data", accd(s), 0);
      chk("rst_ovf", ovf[s], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();

    // Handshake latency on the first sample of a 1,0,1,1 frame.
    stim = '{1, 0, 1, 1};
    @(negedge clk);
    dat[0] = 8'd1;
    req[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t_rise", ack[0], (k == 3) ? 1 : 0);
    end
    repeat (4) tick();
    chk("t_hold", ack[0], 1);
    @(negedge clk);
    req[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t_fall", ack[0], (k == 3) ? 0 : 1);
    end
    run_frame(0, 4, 1);
    repeat (2) tick();
    chk("basic_pulses", xfer_a, 1);
    chk("basic_drop", vld[0], 0);

    stim = '{255, 255, 0, 0};
    run_frame(1, 2, 0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) stim[i] = $urandom_range(0, 255);
      run_frame(0, 4, 0);
    end
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 2; i++) stim[i] = $urandom_range(0, 255);
      run_frame(1, 2, 0);
    end

    // Backpressure: frame held in EMIT while a request with 7 waits.
    repeat (2) tick();
    rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) stim[i] = $urandom_range(0, 255);
    run_frame(0, 4, 0);
    held = accd(0);
    @(negedge clk);
    dat[0] = 8'd7;
    req[0] = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (ack[0]) seen = 1'b1;
    end
    chk("bp_no_ack", seen, 0);
    chk("bp_data", accd(0), held);
    chk("bp_valid", vld[0], 1);
    chk("bp_xfers", xfer_a, exp_xa - 1);
    @(negedge clk);
    rdy[0] = 1'b1;
    for (int i = 0; i < 40 && !ack[0]; i++) tick();
    chk("bp_ack", ack[0], 1);
    chk("bp_xfer_done", xfer_a, exp_xa);
    req_down(0);
    stim[0] = 7;
    for (int i = 1; i < 4; i++) stim[i] = $urandom_range(0, 255);
    run_frame(0, 4, 1);

    // Reset in the middle of a frame with the request still high.
    repeat (2) tick();
    req_up(0, 8'd5);
    req_down(0);
    req_up(0, 8'd5);
    req_down(0);
    req_up(0, 8'd9);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("mr_ack", ack[0], 0);
    chk("mr_valid", vld[0], 0);
    chk("mr_data", accd(0), 0);
    chk("mr_ovf", ovf[0], 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (ack[0]) seen = 1'b1;
    end
    chk("mr_no_ack", seen, 0);
    req_down(0);
    repeat (4) tick();
    stim = '{2, 2, 2, 2};
    run_frame(0, 4, 0);

    repeat (3) tick();
    chk("xfers_a", xfer_a, exp_xa);
    chk("xfers_b", xfer_b, exp_xb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Clocked downstream consumer for the asynchronous adder stage. It receives each sum over a four-phase bundled-data request/acknowledge channel and synchronises the request into the `clk` domain. It accumulates `COUNT` consecutive sums into a frame total and presents that total on a valid/ready output for a synchronous sink. It converts the handshake-driven adder pipeline into a framed, clocked result stream.

## Interface
- `WIDTH`, 8: width of incoming sum data.
- `ACC_WIDTH`, 16: accumulator/result width; must be ≥ `WIDTH`.
- `COUNT`, 4: sums per frame; must be ≥ 1.
- `SYNC_STAGES`, 2: flip-flops in the request synchroniser; must be ≥ 2.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `sum_req`  in  1  four-phase request from the adder; asynchronous to `clk`.
- `sum_data`  in  `WIDTH`  bundled data; stable from `sum_req` rise until `sum_ack` rise.
- `sum_ack`  out  1  four-phase acknowledge, registered.
- `acc_valid`  out  1  frame result valid, registered.
- `acc_ready`  in  1  sink ready.
- `acc_data`  out  `ACC_WIDTH`  frame total, registered.
- `acc_ovf`  out  1  overflow occurred in this frame; qualified by `acc_valid`.

## Operation
- `req_s` is `sum_req` after `SYNC_STAGES` flops. Only `req_s` is used by the FSM.
- FSM states are `ARM`, `IDLE`, `ACK` and `EMIT`.
- `ARM`: entered on reset. Waits for `req_s==0`, then goes to `IDLE`. A request already high at reset release is never accepted.
- `IDLE`: on `req_s==1`, capture `sum_data`, update `acc` and `cnt`, set `sum_ack=1`, and go to `ACK`.
- `ACK`: hold `sum_ack=1` until `req_s==0`. On that edge clear `sum_ack`.
  - If `cnt==COUNT`, go to `EMIT`.
  - Otherwise go to `IDLE`.
- `EMIT`: `acc_valid=1`; `acc_data` and `acc_ovf` are held stable.
  - On `acc_valid && acc_ready`, clear `acc`, `cnt` and the overflow flag, drop `acc_valid`, and go to `IDLE`.
  - No request is acknowledged while in `EMIT`; this is the backpressure to the adder.
- Arithmetic: `acc_next = acc + zero_extend(sum_data)`, computed at `ACC_WIDTH+1` bits. The carry out sets the sticky frame overflow flag.
- `cnt` counts 0..`COUNT` and is `$clog2(COUNT+1)` bits wide.
- `acc_data` mirrors the internal `acc`. It is only meaningful while `acc_valid` is high.

## Timing
- Reset values: `sum_ack=0`, `acc_valid=0`, `acc_data=0`, `acc_ovf=0`, `acc=0`, `cnt=0`, state `ARM`, synchroniser flops 0.
- Latency from `sum_req` rise to `sum_ack` rise is exactly `SYNC_STAGES+1` clk edges, with `sum_req` set up before the first edge.
- Latency from `sum_req` fall to `sum_ack` fall is exactly `SYNC_STAGES+1` edges.
- `sum_data` is sampled on the same edge that sets `sum_ack`.
- `acc_valid` rises on the same edge that clears the final `sum_ack` of a frame.
- `acc_valid` falls on the edge following an accepted transfer (`acc_valid && acc_ready` sampled high).
- Minimum frame turnaround: `COUNT` × (2·(`SYNC_STAGES`+1)) cycles plus 1 cycle in `EMIT`.
- Reset asserted mid-operation, in any state: all outputs return to reset values on that edge. A partial frame is discarded, and `sum_ack` drops even if `sum_req` is still high. The block re-arms via `ARM`.
- `COUNT=1`: every sum is emitted as its own frame.

## Configuration
- Macro `SUM_ACC_SAT_EN`.
- Defined: on carry out, `acc` clamps to all-ones and stays there for the rest of the frame; `acc_ovf=1`.
- Undefined: `acc` wraps modulo 2^`ACC_WIDTH`; `acc_ovf=1`.

## Test plan
- Basic frame: reset, then `COUNT=4`, `acc_ready=1`; send 1, 0, 1, 1 -> exactly one `acc_valid` pulse with `acc_data=3`, `acc_ovf=0`.
- Overflow: `WIDTH=8`, `ACC_WIDTH=8`, `COUNT=2`; send 255, 255 -> `acc_data=254`, `acc_ovf=1` without the macro; `acc_data=255`, `acc_ovf=1` with `SUM_ACC_SAT_EN`.
- Backpressure: complete a frame, hold `acc_ready=0` for 20 cycles, raise `sum_req` with data 7 -> `sum_ack` stays 0 and `acc_data` is unchanged. After `acc_ready=1` the transfer completes, then 7 is acked as the first sample of the new frame.
- Handshake timing: `SYNC_STAGES=2`; raise `sum_req` -> `sum_ack` rises exactly 3 edges later and stays high until 3 edges after `sum_req` falls.
- Reset mid-frame: after 2 of 4 samples, assert `reset` for 1 cycle while `sum_req` is high -> all outputs are 0 and `sum_ack` stays 0 until `sum_req` falls and rises again. The next full frame of 2, 2, 2, 2 yields `acc_data=8`.
